hazard3_operand_bypass: RTL
===========================

// Module: hazard3_operand_bypass
// PURPOSE
//  Sits between the 1W2R regfile read ports and the X-stage ALU operand inputs.
//  Regfile read data is registered (1-cycle), and the regfile does no write-to-read check.
//  This block resolves each operand cycle by cycle from four sources, in priority order:
//   - M-stage result forwarding
//   - W-stage result forwarding
//   - the same-cycle write/read collision register
//   - raw regfile data
//  It also holds X operands across X stalls and flags load-use hazards.
// PARAMETERS
//  W_DATA  32  operand/register width
//  W_ADDR  5   register address width; address 0 is x0 (reads as zero)
// PORTS
//  clk           in   1       core clock
//  rst_n         in   1       async reset, active low
//  d_raddr1/2    in   W_ADDR  D-stage read addresses (same nets drive regfile raddr1/2)
//  rf_rdata1/2   in   W_DATA  regfile registered read data
//  x_stall       in   1       X holds its instruction this cycle (D is held too)
//  m_valid       in   1       M stage holds a register-writing instruction
//  m_rd          in   W_ADDR  M-stage destination
//  m_result      in   W_DATA  M-stage result
//  m_result_vld  in   1       m_result is final (0 while a load is outstanding)
//  wen/waddr     in   1/W_ADDR  W-stage regfile write (same nets as regfile write port)
//  wdata         in   W_DATA  W-stage write data
//  x_op1/x_op2   out  W_DATA  resolved X operands (combinational)
//  x_op_stall    out  1       load-use hazard: X must stall (caller ORs into x_stall)
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst_n is asynchronous, active low.
//    All state resets to 0: x_raddrN, holdN, hold_vld, collN, coll_vldN.
//    Out of reset, x_op1/2 = 0 (x_raddr = x0) and x_op_stall = 0.
//  - x_raddrN:
//    - Loads d_raddrN on every cycle with !x_stall.
//    - Holds its value while x_stall = 1.
//  - Collision register, per operand, updated every cycle:
//    - coll_vldN <= wen && waddr == d_raddrN && waddr != 0.
//    - collN <= wdata.
//  - Hold register:
//    - On each cycle with x_stall = 1: holdN <= x_opN and hold_vld <= 1.
//    - On a cycle with x_stall = 0: hold_vld <= 0.
//  - Operand select, per operand:
//    - If x_raddrN == 0: output 0.
//    - Else if m_valid && m_rd == x_raddrN: output m_result.
//    - Else if wen && waddr == x_raddrN: output wdata.
//    - Else if hold_vld: output holdN.
//    - Else if coll_vldN: output collN.
//    - Else: output rf_rdataN.
//  - x_op_stall = OR over N of (m_valid && m_rd == x_raddrN && m_rd != 0 && !m_result_vld).
//  - Latency: forwarding adds no cycles. Only the load-use case stalls, until m_result_vld = 1.
//  - Simultaneous events:
//    - M and W targeting the same register: M wins (younger producer).
//    - Write to x0: never forwarded, never captured.
//  - Stall entry: the operand resolved in the first stalled cycle is captured.
//    This covers the regfile re-reading D's address while X is stalled.
//  - Stall exit: rf_rdata in the following cycle belongs to the newly advanced instruction.
//  - Reset mid-stall clears hold_vld. The pipeline flush is the caller's responsibility.
// CONFIGURATION
//  HAZARD3_BYPASS_COLLISION_EN
//  - Defined: collision registers present, as above.
//  - Undefined:
//    - collN and coll_vldN are removed, and the collision step is dropped from operand select.
//    - The regfile must then be built write-first (with read/write check).
// STRUCTURE
//  - Package hazard3_pipe_pkg:
//    - REG_ZERO constant.
//    - Forward-select encoding FWD_ZERO/FWD_M/FWD_W/FWD_HOLD/FWD_COLL/FWD_RF.
//  - Sub-module hazard3_operand_sel, instantiated twice (one per operand). It contains:
//    - x_raddrN, holdN, collN, coll_vldN;
//    - the priority mux;
//    - the per-operand load-use term.
//  - Top level: shared hold_vld flop and the OR of the two stall terms.
// TESTING
//  1. Reset, then d_raddr1 = 5 and rf_rdata1 = 0x11 with no forwarding.
//     -> x_op1 = 0x11 in the cycle after D advances.
//  2. m_valid = 1, m_rd = 5, m_result = 0xAA, and x_raddr1 = 5.
//     -> x_op1 = 0xAA that same cycle.
//     Add wen with waddr = 5 and wdata = 0xBB: x_op1 stays 0xAA.
//  3. wen, waddr = 7, wdata = 0x77 in the same cycle that d_raddr2 = 7, with stale rf_rdata2 = 0x0.
//     -> next cycle x_op2 = 0x77 (macro on).
//  4. x_stall held 3 cycles while rf_rdata1 changes to the D operand 0x99.
//     -> x_op1 keeps the original 0x11 throughout.
//     A W write of 0x22 to x_raddr1 mid-stall -> x_op1 = 0x22 from then on.
//  5. m_valid = 1, m_rd = 3, m_result_vld = 0, x_raddr2 = 3.
//     -> x_op_stall = 1.
//     Then m_result_vld = 1, m_result = 0x5 -> x_op_stall = 0 and x_op2 = 0x5.
//  6. x_raddr1 = 0 with m_rd = 0 and wen to waddr 0 (wdata = 0xFF).
//     -> x_op1 = 0 and x_op_stall = 0.
//     Assert rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard3_pipe_pkg.sv
// Shared pipeline constants and the operand forward-select encoding.
package hazard3_pipe_pkg;

    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_M    = 3'd1,
        FWD_W    = 3'd2,
        FWD_HOLD = 3'd3,
        FWD_COLL = 3'd4,
        FWD_RF   = 3'd5
    } fwd_sel_e;

endpackage

// File: rtl/hazard3_operand_sel.sv
// One X-stage operand: address tracking, hold/collision capture, priority mux
// and load-use term. Collision capture is built only with HAZARD3_BYPASS_COLLISION_EN.
module hazard3_operand_sel
    import hazard3_pipe_pkg::*;
#(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_ADDR = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] d_raddr,
    input  logic [W_DATA-1:0] rf_rdata,
    input  logic              x_stall,
    input  logic              hold_vld,
    input  logic              m_valid,
    input  logic [W_ADDR-1:0] m_rd,
    input  logic [W_DATA-1:0] m_result,
    input  logic              m_result_vld,
    input  logic              wen,
    input  logic [W_ADDR-1:0] waddr,
    input  logic [W_DATA-1:0] wdata,
    output logic [W_DATA-1:0] x_op_c,
    output logic              load_use_c
);

    localparam logic [W_ADDR-1:0] ZERO_ADDR = W_ADDR'(REG_ZERO);

    logic [W_ADDR-1:0] x_raddr;
    logic [W_DATA-1:0] hold;
    logic              m_hit;
    logic              w_hit;
    fwd_sel_e          sel;

    // X address follows D unless stalled; the resolved operand is captured while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_raddr <= '0;
            hold    <= '0;
        end else begin
            if (!x_stall) begin
                x_raddr <= d_raddr;
            end
            if (x_stall) begin
                hold <= x_op_c;
            end
        end
    end

`ifdef HAZARD3_BYPASS_COLLISION_EN
    logic              coll_vld;
    logic [W_DATA-1:0] coll;

    // Regfile returns pre-write data when D reads the register W writes this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_vld <= 1'b0;
            coll     <= '0;
        end else begin
            coll_vld <= wen && (waddr == d_raddr) && (waddr != ZERO_ADDR);
            coll     <= wdata;
        end
    end
`endif

    assign m_hit = m_valid && (m_rd == x_raddr);
    assign w_hit = wen && (waddr == x_raddr);

    always_comb begin
        sel = FWD_RF;
        if (x_raddr == ZERO_ADDR) begin
            sel = FWD_ZERO;
        end else if (m_hit) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end else if (hold_vld) begin
            sel = FWD_HOLD;
`ifdef HAZARD3_BYPASS_COLLISION_EN
        end else if (coll_vld) begin
            sel = FWD_COLL;
`endif
        end
    end

    always_comb begin
        x_op_c = rf_rdata;
        case (sel)
            FWD_ZERO: x_op_c = '0;
            FWD_M:    x_op_c = m_result;
            FWD_W:    x_op_c = wdata;
            FWD_HOLD: x_op_c = hold;
`ifdef HAZARD3_BYPASS_COLLISION_EN
            FWD_COLL: x_op_c = coll;
`endif
            default:  x_op_c = rf_rdata;
        endcase
    end

    assign load_use_c = m_hit && (m_rd != ZERO_ADDR) && !m_result_vld;

endmodule

// File: rtl/hazard3_operand_bypass.sv
// X-stage operand bypass: two operand selectors, shared hold-valid flop and
// load-use stall. Optional collision capture via HAZARD3_BYPASS_COLLISION_EN.
module hazard3_operand_bypass #(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_ADDR = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] d_raddr1,
    input  logic [W_ADDR-1:0] d_raddr2,
    input  logic [W_DATA-1:0] rf_rdata1,
    input  logic [W_DATA-1:0] rf_rdata2,
    input  logic              x_stall,
    input  logic              m_valid,
    input  logic [W_ADDR-1:0] m_rd,
    input  logic [W_DATA-1:0] m_result,
    input  logic              m_result_vld,
    input  logic              wen,
    input  logic [W_ADDR-1:0] waddr,
    input  logic [W_DATA-1:0] wdata,
    output logic [W_DATA-1:0] x_op1,
    output logic [W_DATA-1:0] x_op2,
    output logic              x_op_stall
);

    logic hold_vld;
    logic load_use1;
    logic load_use2;

    // Hold registers are valid in every cycle that follows a stalled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld <= 1'b0;
        end else begin
            hold_vld <= x_stall;
        end
    end

    hazard3_operand_sel #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_sel1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_raddr      (d_raddr1),
        .rf_rdata     (rf_rdata1),
        .x_stall      (x_stall),
        .hold_vld     (hold_vld),
        .m_valid      (m_valid),
        .m_rd         (m_rd),
        .m_result     (m_result),
        .m_result_vld (m_result_vld),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .x_op_c       (x_op1),
        .load_use_c   (load_use1)
    );

    hazard3_operand_sel #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_sel2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_raddr      (d_raddr2),
        .rf_rdata     (rf_rdata2),
        .x_stall      (x_stall),
        .hold_vld     (hold_vld),
        .m_valid      (m_valid),
        .m_rd         (m_rd),
        .m_result     (m_result),
        .m_result_vld (m_result_vld),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .x_op_c       (x_op2),
        .load_use_c   (load_use2)
    );

    assign x_op_stall = load_use1 || load_use2;

endmodule
